// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array input feeder.
// Lane width default, feeder FSM state and default-geometry FIFO entry layout.
package sa_pkg;

   localparam int SA_DATA_W = 8;
   localparam int SA_ROWS   = 8;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } feed_state_t;

   typedef struct packed {
      logic                          last;
      logic [SA_ROWS*SA_DATA_W-1:0]  data;
   } fifo_entry_t;

endpackage

// File: rtl/sa_sync_fifo.sv
// Single-clock FIFO with registered occupancy count and fall-through head.
// Push into a full FIFO and pop from an empty one are ignored.
module sa_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/sa_skew_feeder.sv
// Systolic-array edge feeder: FIFO-buffered row vectors driven out with
// diagonal skew, plus ROWS-1 bubbles after each tile's last vector.
module sa_skew_feeder
   import sa_pkg::*;
#(
   parameter int ROWS       = 8,
   parameter int DATA_W     = SA_DATA_W,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [ROWS*DATA_W-1:0]        in_data,
   input  logic                          in_last,
   input  logic                          stall,
   output logic [ROWS*DATA_W-1:0]        out_data,
   output logic [ROWS-1:0]               out_valid,
   output logic [ROWS-1:0]               out_last,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int VW = ROWS*DATA_W;
   localparam int EW = VW + 1;
   localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int SW = DATA_W + 2;

   logic [EW-1:0]  fifo_rdata;
   logic           fifo_full, fifo_empty;
   logic           push, pop, step;
   feed_state_t    state;
   logic [CW-1:0]  flush_cnt;
   logic           ent_vld, ent_last;
   logic [VW-1:0]  ent_data;
   logic [ROWS-1:0] row_busy;

   assign in_ready = ~fifo_full;
   assign push     = in_valid & in_ready;
   assign step     = ~stall;
   assign pop      = step && (state == RUN) && !fifo_empty;

   sa_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({in_last, in_data}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_level)
   );

   // A step without a pop injects an all-zero bubble.
   assign ent_vld  = pop;
   assign ent_last = pop & fifo_rdata[VW];
   assign ent_data = pop ? fifo_rdata[VW-1:0] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         flush_cnt <= '0;
      end else if (step) begin
         if (state == RUN) begin
            if (pop && fifo_rdata[VW] && (ROWS > 1)) begin
               state     <= FLUSH;
               flush_cnt <= CW'(ROWS-1);
            end
         end else begin
            flush_cnt <= flush_cnt - 1'b1;
            if (flush_cnt == CW'(1)) state <= RUN;
         end
      end
   end

   // Row r: r+1 stage delay line of {valid, last, lane}; the last stage is the output register.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [r:0][SW-1:0] pipe;
      logic [SW-1:0]      ent;
      logic               rb;

      assign ent = {ent_vld, ent_last, ent_data[r*DATA_W +: DATA_W]};

      if (r == 0) begin : g_first
         always_ff @(posedge clk or posedge rst) begin
            if (rst)       pipe <= '0;
            else if (step) pipe <= ent;
         end
      end else begin : g_chain
         always_ff @(posedge clk or posedge rst) begin
            if (rst)       pipe <= '0;
            else if (step) pipe <= {pipe[r-1:0], ent};
         end
      end

      always_comb begin
         rb = 1'b0;
         for (int k = 0; k <= r; k++) rb = rb | pipe[k][SW-1];
      end

      assign row_busy[r]                  = rb;
      assign out_valid[r]                 = pipe[r][SW-1];
      assign out_last[r]                  = pipe[r][SW-2];
      assign out_data[r*DATA_W +: DATA_W] = pipe[r][DATA_W-1:0];
   end

   assign busy = !fifo_empty || (state == FLUSH) || (|row_busy);

endmodule

// File: doc/sa_skew_feeder.md
Name: sa_skew_feeder

Overview:
- Parametrised input feeder for the SA_CORE systolic array.
- Accepts one full row-vector of activations per valid/ready beat and buffers it in a FIFO.
- Drives the array edge with diagonal skew: row r is delayed r steps relative to row 0.
- Inserts ROWS-1 zero bubbles after each tile's last vector so tiles never overlap in the wavefront. Honours a downstream stall.

Parameters:
- ROWS, 8: array rows / input lanes (>=1).
- DATA_W, 8: bits per lane element.
- FIFO_DEPTH, 16: input FIFO entries; power of two, >=2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input vector present.
- in_ready  out  1  FIFO can accept; high when FIFO count < FIFO_DEPTH.
- in_data  in  ROWS*DATA_W  lane r at bits [r*DATA_W +: DATA_W].
- in_last  in  1  vector is the final one of its tile.
- stall  in  1  freeze skew pipeline and pops; FIFO writes continue.
- out_data  out  ROWS*DATA_W  skewed lane data, registered.
- out_valid  out  ROWS  per-row element valid, registered.
- out_last  out  ROWS  per-row last-of-tile marker, registered.
- busy  out  1  FIFO non-empty OR state==FLUSH OR any skew-stage valid set.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, asynchronous on rst high: FIFO empty, all skew registers cleared, state RUN, flush counter 0.
  - Outputs under reset: out_data=0, out_valid=0, out_last=0, busy=0, fifo_level=0, in_ready=1 after release.
- Push: occurs on an edge where in_valid && in_ready. Stores {in_last, in_data}.
- in_ready is derived from the registered count only. A pop does not raise it in the same cycle.
- Advance step: any edge with stall=0.
  - On a step, a row-0 entry is loaded into stage 0.
  - Each row r takes its delay-line stage r-1 value into stage r.
  - Row r has r cascaded stages before its output register. Row 0 has none.
- State machine:
  - RUN, on a step:
    - FIFO non-empty: pop the head into the row-0 entry with valid=1.
    - FIFO empty: inject a bubble (data 0, valid 0, last 0).
    - Popped entry has last=1 and ROWS>1: go to FLUSH, counter=ROWS-1.
  - FLUSH, on a step: inject a bubble, decrement counter. When counter reaches 1 on a step, return to RUN; the next step may pop.
  - ROWS==1: FLUSH is never entered.
- Stall: no pop, no state/counter change, all skew and output registers hold. Pushes still occur.
- Latency, no stall, FIFO empty beforehand: a vector pushed at edge E appears on row 0 after edge E+1 and on row r after edge E+1+r.
  - out_last[r] asserts in the same cycle as that row's element from the last vector.
- Push and pop on the same edge: both take effect; level unchanged.
- Push into an empty FIFO is not bypassed: pop happens no earlier than the next edge.
- Bubble lanes drive data 0, never stale data.
- Reset asserted mid-tile: all in-flight data is discarded with no partial drain.

Decomposition:
- Shared package sa_pkg:
  - DATA_W default.
  - Enum feed_state_t {RUN, FLUSH}.
  - Typedef for the FIFO entry struct {last, data}.
- Sub-module sa_sync_fifo: parametrised width/depth.
  - Ports: push/pop, full/empty, count.
  - Same clk/rst convention.
- Skew delay lines are written inline with a generate loop over rows.

Test Plan:
- Single vector: ROWS=8, lane r = r+1, in_last=1, pushed at edge E.
  - Row r shows value r+1 with valid=1 and last=1 exactly after edge E+1+r.
  - busy drops after row 7 drains.
- Back-to-back tiles: two 3-vector tiles pushed on consecutive cycles.
  - Row 0 shows valid for 3 cycles, then exactly 7 bubble cycles, then the second tile.
  - No row ever carries both tiles' elements in the same diagonal.
- Full FIFO: DEPTH=16, stall=1, 20 vectors offered.
  - in_ready drops after 16 pushes; fifo_level=16.
  - Release stall: one pop per cycle; in_ready returns one cycle after the first pop.
- Stall mid-stream: assert stall for 4 cycles during a tile.
  - All outputs hold for exactly 4 cycles, then resume in order; no element is lost or duplicated.
- Reset mid-flush: assert rst while in FLUSH with 5 vectors queued.
  - Outputs are 0 immediately; fifo_level=0; after release the first new push emerges on row 0 at E+1.
- ROWS=1 build: a tile of 4 vectors followed by a new tile.
  - No bubbles inserted between tiles; out_valid is continuous for 8 cycles.
